// File: rtl/cmsdk_gpio_pkg.sv
// Shared defaults for the GPIO input conditioning path.
package cmsdk_gpio_pkg;

  localparam int          GPIO_WIDTH       = 16;
  localparam int          GPIO_CNT_W       = 8;
  localparam logic [15:0] GPIO_RESET_VALUE = 16'h0000;

endpackage : cmsdk_gpio_pkg

// File: rtl/cmsdk_gpio_db_bit.sv
// One-pin conditioner: 2-flop synchroniser, stable-sample counter,
// debounced level flop and change-pulse flop.
module cmsdk_gpio_db_bit import cmsdk_gpio_pkg::*; #(
  parameter int   CNT_W       = GPIO_CNT_W,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             padin,
  input  logic             tick,
  input  logic [CNT_W-1:0] thresh,
  input  logic             bypass,
  output logic             db,
  output logic             change
);

  // One extra bit so cnt+1 can never wrap before the compare.
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thr_eff;

  // Next-state: bypass follows the synchronised pad, otherwise count
  // consecutive differing ticks and accept the new level at threshold.
  always_comb begin
    thr_eff = (thresh == '0) ? ONE : {1'b0, thresh};
    cnt_inc = {1'b0, cnt_q} + ONE;
    db_d    = db_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    if (bypass) begin
      db_d  = s2_q;
      cnt_d = '0;
      chg_d = s2_q ^ db_q;
    end else if (tick) begin
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_inc >= thr_eff) begin
        db_d  = s2_q;
        cnt_d = '0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Synchroniser and debounce state; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= RESET_VALUE;
      s2_q  <= RESET_VALUE;
      db_q  <= RESET_VALUE;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= padin;
      s2_q  <= s1_q;
      db_q  <= db_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign db     = db_q;
  assign change = chg_q;

endmodule : cmsdk_gpio_db_bit

// File: rtl/cmsdk_gpio_in_debounce.sv
// GPIO input conditioning: shared sample-tick prescaler feeding one
// synchroniser/debouncer per pin. Output drives GPIO PORTIN.
module cmsdk_gpio_in_debounce import cmsdk_gpio_pkg::*; #(
  parameter int               WIDTH       = GPIO_WIDTH,
  parameter int               CNT_W       = GPIO_CNT_W,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(GPIO_RESET_VALUE)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] PADIN,
  input  logic [CNT_W-1:0] THRESH,
  input  logic [WIDTH-1:0] BYPASS,
  output logic [WIDTH-1:0] PORTIN_DB,
  output logic [WIDTH-1:0] CHANGE
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  // Prescaler wraps at PRESCALE-1; tick marks the wrap cycle.
  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PS_ONE;
  end

  // Prescaler state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cmsdk_gpio_db_bit #(
      .CNT_W       (CNT_W),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_db_bit (
      .clk    (HCLK),
      .rst    (HRESET),
      .padin  (PADIN[i]),
      .tick   (tick),
      .thresh (THRESH),
      .bypass (BYPASS[i]),
      .db     (PORTIN_DB[i]),
      .change (CHANGE[i])
    );
  end

endmodule : cmsdk_gpio_in_debounce

// File: tb/tb_cmsdk_gpio_in_debounce.sv
// Directed bench for cmsdk_gpio_in_debounce (PRESCALE=1 and PRESCALE=4).
module tb_cmsdk_gpio_in_debounce;

  logic        HCLK;
  logic        HRESET;
  logic [15:0] PADIN, BYPASS, PORTIN_DB, CHANGE;
  logic [7:0]  THRESH;
  logic [15:0] padin_ps, bypass_ps, portin_ps, change_ps;
  logic [7:0]  thresh_ps;

  int checks = 0;
  int errors = 0;

  cmsdk_gpio_in_debounce #(.WIDTH(16), .CNT_W(8), .PRESCALE(1), .RESET_VALUE(16'h0000)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADIN(PADIN), .THRESH(THRESH),
    .BYPASS(BYPASS), .PORTIN_DB(PORTIN_DB), .CHANGE(CHANGE)
  );

  cmsdk_gpio_in_debounce #(.WIDTH(16), .CNT_W(8), .PRESCALE(4), .RESET_VALUE(16'h0000)) dut_ps (
    .HCLK(HCLK), .HRESET(HRESET), .PADIN(padin_ps), .THRESH(thresh_ps),
    .BYPASS(bypass_ps), .PORTIN_DB(portin_ps), .CHANGE(change_ps)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    int lat;
    HRESET    = 1'b1;
    PADIN     = 16'hFFFF;
    THRESH    = 8'd4;
    BYPASS    = 16'h0000;
    padin_ps  = 16'h0000;
    thresh_ps = 8'd2;
    bypass_ps = 16'h0000;

    // Reset holds outputs low despite PADIN all ones.
    step(3);
    chk("rst_db", PORTIN_DB, 16'h0000);
    chk("rst_chg", CHANGE, 16'h0000);
    chk("rst_db_ps", portin_ps, 16'h0000);

    // Release: next edge is E0, update at E5 with THRESH=4.
    HRESET = 1'b0;
    step(5);
    chk("post_rst_e4", PORTIN_DB, 16'h0000);
    step(1);
    chk("post_rst_e5", PORTIN_DB, 16'hFFFF);
    chk("post_rst_chg", CHANGE, 16'hFFFF);
    step(1);
    chk("post_rst_chg_off", CHANGE, 16'h0000);

    // Simultaneous fall, THRESH=3: update at E4 on every pin.
    THRESH = 8'd3;
    PADIN  = 16'h0000;
    step(4);
    chk("sim_e3", PORTIN_DB, 16'hFFFF);
    chk("sim_e3_chg", CHANGE, 16'h0000);
    step(1);
    chk("sim_e4", PORTIN_DB, 16'h0000);
    chk("sim_chg", CHANGE, 16'hFFFF);
    step(1);
    chk("sim_chg_off", CHANGE, 16'h0000);

    // Clean edge on pin 0, THRESH=4: rises at E5, one CHANGE pulse.
    THRESH = 8'd4;
    PADIN  = 16'h0001;
    step(5);
    chk("clean_e4", PORTIN_DB, 16'h0000);
    chk("clean_e4_chg", CHANGE, 16'h0000);
    step(1);
    chk("clean_e5", PORTIN_DB, 16'h0001);
    chk("clean_chg", CHANGE, 16'h0001);
    step(1);
    chk("clean_chg_off", CHANGE, 16'h0000);
    chk("clean_hold", PORTIN_DB, 16'h0001);
    PADIN = 16'h0000;
    step(8);
    chk("clean_back", PORTIN_DB, 16'h0000);

    // Bounce on pin 3: 3 high, 1 low, then high; rises at F5.
    PADIN = 16'h0008;
    step(3);
    PADIN = 16'h0000;
    step(1);
    chk("bounce_glitch", PORTIN_DB, 16'h0000);
    PADIN = 16'h0008;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("bounce_hold%0d", k), PORTIN_DB, 16'h0000);
      chk($sformatf("bounce_nochg%0d", k), CHANGE, 16'h0000);
    end
    step(1);
    chk("bounce_rise", PORTIN_DB, 16'h0008);
    chk("bounce_chg", CHANGE, 16'h0008);
    PADIN = 16'h0000;
    step(8);
    chk("bounce_back", PORTIN_DB, 16'h0000);

    // Bypass pin 0, THRESH=200: pin 0 follows in 3 edges, pin 1 filtered.
    THRESH = 8'd200;
    BYPASS = 16'h0001;
    PADIN  = 16'h0003;
    step(2);
    chk("byp_e1", PORTIN_DB, 16'h0000);
    step(1);
    chk("byp_e2", PORTIN_DB, 16'h0001);
    chk("byp_chg", CHANGE, 16'h0001);
    step(20);
    chk("byp_pin1_filtered", PORTIN_DB, 16'h0001);
    PADIN = 16'h0002;
    step(2);
    chk("byp_fall_e1", PORTIN_DB, 16'h0001);
    step(1);
    chk("byp_fall_e2", PORTIN_DB, 16'h0000);
    chk("byp_fall_chg", CHANGE, 16'h0001);
    PADIN  = 16'h0000;
    BYPASS = 16'h0000;
    step(4);
    chk("byp_back", PORTIN_DB, 16'h0000);

    // THRESH=0 acts as 1: update at E2.
    THRESH = 8'd0;
    PADIN  = 16'h0020;
    step(2);
    chk("thr0_e1", PORTIN_DB, 16'h0000);
    step(1);
    chk("thr0_e2", PORTIN_DB, 16'h0020);
    chk("thr0_chg", CHANGE, 16'h0020);

    // Prescale 4, THRESH=2: pin 7 latency within 7..10 edges.
    padin_ps = 16'h0080;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (portin_ps[7] && lat == 99) lat = k;
    end
    chk("ps_lat_min", 32'(lat >= 7), 32'd1);
    chk("ps_lat_max", 32'(lat <= 10), 32'd1);
    chk("ps_db", portin_ps, 16'h0080);

    // Async reset mid-count: clears immediately, no CHANGE pulse.
    THRESH = 8'd4;
    PADIN  = 16'hFFFF;
    step(8);
    chk("pre_rst_db", PORTIN_DB, 16'hFFFF);
    PADIN = 16'h0000;
    step(2);
    #2;
    HRESET = 1'b1;
    #1;
    chk("midrst_db", PORTIN_DB, 16'h0000);
    chk("midrst_chg", CHANGE, 16'h0000);
    chk("midrst_db_ps", portin_ps, 16'h0000);
    step(1);
    HRESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("after_rst_chg%0d", k), CHANGE, 16'h0000);
    end
    chk("after_rst_db", PORTIN_DB, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cmsdk_gpio_in_debounce
